cfq_arb: RTL and testbench
==========================

# cfq_arb

Two-port controller that shares one sequential shift-add 8x4 multiplier (`cfq` datapath) between two requesters. It arbitrates round-robin, latches the winner's operands, and runs B_W shift-add iterations. It then returns the full-width product with a one-cycle done pulse to the served requester. It sits between client logic and the multiply resource, so the client needs no multiplier of its own.

## Interface
- A_W, 8, multiplicand width
- B_W, 4, multiplier width; also the number of CALC iterations
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous active-low reset
- req0  in  1  requester 0 request; held high with a0/b0 stable until done0
- a0  in  A_W  requester 0 multiplicand
- b0  in  B_W  requester 0 multiplier
- req1  in  1  requester 1 request; same rules as req0
- a1  in  A_W  requester 1 multiplicand
- b1  in  B_W  requester 1 multiplier
- gnt  out  2  one-hot owner of the multiplier; 00 when idle
- busy  out  1  high in any state other than IDLE
- prod  out  A_W+B_W  product of the served request; holds its value until the next done
- done0  out  1  one-cycle pulse: prod is valid for requester 0
- done1  out  1  one-cycle pulse: prod is valid for requester 1

## Operation
- States: IDLE, CALC, DONE.
- IDLE, no req: stay; gnt=00, busy=0.
- IDLE, any req: on the edge, pick the winner, then go to CALC.
  - Winner is the sole requester, or, if both request, the requester not served last.
  - Load a_sh = zero-extended a (A_W+B_W bits), b_sh = b, acc = 0, cnt = 0.
  - Set gnt one-hot and update last-served pointer.
- CALC, each edge:
  - If b_sh[0], acc += a_sh (mod 2^(A_W+B_W), never overflows).
  - a_sh <<= 1; b_sh >>= 1; cnt++.
  - On the edge where cnt == B_W-1: prod <= final acc, state goes to DONE.
- DONE: done of the owner is high for exactly this cycle; next edge goes to IDLE, gnt cleared.
- Operands are sampled only at the grant edge. Later changes on a/b do not affect the result.
- Requests arriving while busy wait; they are not dropped.
- The requester must deassert req on the edge ending its done cycle. A req still high in IDLE is treated as a new request.
- Last-served pointer resets to requester 1, so requester 0 wins the first tie.
- Reset (any time, including mid-CALC):
  - state=IDLE, gnt=00, busy=0, prod=0, done0=done1=0, acc/a_sh/b_sh/cnt=0, pointer=1.
  - No done is emitted for the aborted operation.

## Timing
- Grant edge E0 → CALC edges E1..E_B_W → DONE cycle between E_B_W and E_B_W+1.
- With B_W=4: done high in the cycle after E4; prod valid in the same cycle.
- Latency from the grant edge to done: B_W+1 edges. Back in IDLE after E_B_W+1; next grant at E_B_W+2 at the earliest.
- Throughput: one product per B_W+2 cycles (6 with defaults).
- gnt and busy change on edges only; they are registered, not combinational from req.
- done0/done1 are registered; they are never both high.

## Configuration
- CFQ_ARB_ZERO_SKIP_EN defined:
  - At the grant edge, if the latched a==0 or b==0, go directly to DONE with prod=0, skipping CALC.
  - done arrives one cycle after the grant edge.
- Not defined: every operation takes the full B_W CALC cycles, regardless of operand values.

## Test plan
- Single request: req0, a0=0x1F, b0=0x2.
  - Expect gnt=01 after the grant edge, done0 exactly 5 edges after grant, prod=0x03E, done1 stays 0.
- Single request: req1, a1=0x1D, b1=0x3.
  - Expect done1 pulse, prod=0x057, gnt=10 during CALC/DONE.
- Simultaneous requests out of reset:
  - req0 (0xFF×0xF) and req1 (0x1D×0x3) both high.
  - Expect requester 0 served first (prod=0xEF1, done0), then requester 1 (prod=0x057, done1).
  - 6 cycles between the two done pulses.
- Fairness: both reqs held continuously for 4 operations.
  - Expect done pulses alternate 0,1,0,1; never the same requester twice in a row.
- Reset mid-operation: assert rst during the 2nd CALC cycle of 0x1F×0x2.
  - Expect immediate gnt=00, busy=0, prod=0, and no done pulse.
  - After release, the same request completes with prod=0x03E.
- Zero operand: a0=0x00, b0=0x9.
  - With CFQ_ARB_ZERO_SKIP_EN: done0 one cycle after grant, prod=0.
  - Without the macro: done0 after 5 edges, prod=0.

Source files
------------

// File: rtl/cfq_arb.sv
// cfq_arb: round-robin arbiter sharing one sequential shift-add A_W x B_W multiplier
// between two requesters. Optional macro CFQ_ARB_ZERO_SKIP_EN bypasses CALC for zero operands.
module cfq_arb #(
  parameter int A_W = 8,
  parameter int B_W = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req0_i,
  input  logic [A_W-1:0]       a0_i,
  input  logic [B_W-1:0]       b0_i,
  input  logic                 req1_i,
  input  logic [A_W-1:0]       a1_i,
  input  logic [B_W-1:0]       b1_i,
  output logic [1:0]           gnt_o,
  output logic                 busy_o,
  output logic [A_W+B_W-1:0]   prod_o,
  output logic                 done0_o,
  output logic                 done1_o
);

  localparam int P_W   = A_W + B_W;
  localparam int CNT_W = (B_W > 1) ? $clog2(B_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(B_W - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       gnt_q, gnt_d;
  logic             busy_q, busy_d;
  logic [P_W-1:0]   prod_q, prod_d;
  logic             done0_q, done0_d;
  logic             done1_q, done1_d;
  logic             last_q, last_d;
  logic [P_W-1:0]   a_sh_q, a_sh_d;
  logic [B_W-1:0]   b_sh_q, b_sh_d;
  logic [P_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             win1_s;
  logic [A_W-1:0]   a_sel_s;
  logic [B_W-1:0]   b_sel_s;
  logic [P_W-1:0]   acc_sum_s;

  // Arbitration: a tie goes to the requester that was not served last.
  always_comb begin
    win1_s  = req1_i & (~req0_i | ~last_q);
    a_sel_s = win1_s ? a1_i : a0_i;
    b_sel_s = win1_s ? b1_i : b0_i;
  end

  // One shift-add step; the accumulator is as wide as the full product so it never wraps.
  always_comb begin
    if (b_sh_q[0]) begin
      acc_sum_s = acc_q + a_sh_q;
    end else begin
      acc_sum_s = acc_q;
    end
  end

  // Next-state and next-output logic for the IDLE/CALC/DONE controller.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    prod_d  = prod_q;
    last_d  = last_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    done0_d = 1'b0;
    done1_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req0_i || req1_i) begin
          gnt_d   = win1_s ? 2'b10 : 2'b01;
          last_d  = win1_s;
          a_sh_d  = {{B_W{1'b0}}, a_sel_s};
          b_sh_d  = b_sel_s;
          acc_d   = {P_W{1'b0}};
          cnt_d   = {CNT_W{1'b0}};
          state_d = ST_CALC;
`ifdef CFQ_ARB_ZERO_SKIP_EN
          if ((a_sel_s == {A_W{1'b0}}) || (b_sel_s == {B_W{1'b0}})) begin
            prod_d  = {P_W{1'b0}};
            done0_d = ~win1_s;
            done1_d = win1_s;
            state_d = ST_DONE;
          end else begin
            state_d = ST_CALC;
          end
`endif
        end else begin
          gnt_d = 2'b00;
        end
      end
      ST_CALC: begin
        acc_d  = acc_sum_s;
        a_sh_d = a_sh_q << 1;
        b_sh_d = b_sh_q >> 1;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          prod_d  = acc_sum_s;
          done0_d = gnt_q[0];
          done1_d = gnt_q[1];
          state_d = ST_DONE;
        end else begin
          state_d = ST_CALC;
        end
      end
      ST_DONE: begin
        gnt_d   = 2'b00;
        state_d = ST_IDLE;
      end
      default: begin
        gnt_d   = 2'b00;
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and registered outputs; reset abandons any operation without a done pulse.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      gnt_q   <= 2'b00;
      busy_q  <= 1'b0;
      prod_q  <= {P_W{1'b0}};
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      last_q  <= 1'b1;
      a_sh_q  <= {P_W{1'b0}};
      b_sh_q  <= {B_W{1'b0}};
      acc_q   <= {P_W{1'b0}};
      cnt_q   <= {CNT_W{1'b0}};
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      busy_q  <= busy_d;
      prod_q  <= prod_d;
      done0_q <= done0_d;
      done1_q <= done1_d;
      last_q  <= last_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign gnt_o   = gnt_q;
  assign busy_o  = busy_q;
  assign prod_o  = prod_q;
  assign done0_o = done0_q;
  assign done1_o = done1_q;

endmodule

// File: tb/tb_cfq_arb.sv
// Directed, table-driven bench for cfq_arb with hand-computed products and latencies.
module tb_cfq_arb;
  localparam int A_W = 8;
  localparam int B_W = 4;
  localparam int P_W = A_W + B_W;
`ifdef CFQ_ARB_ZERO_SKIP_EN
  localparam int ZLAT = 0;
`else
  localparam int ZLAT = B_W;
`endif

  logic           clk_i = 1'b0;
  logic           rst_ni;
  logic           req0_i, req1_i;
  logic [A_W-1:0] a0_i, a1_i;
  logic [B_W-1:0] b0_i, b1_i;
  logic [1:0]     gnt_o;
  logic           busy_o;
  logic [P_W-1:0] prod_o;
  logic           done0_o, done1_o;

  int checks = 0;
  int errors = 0;

  cfq_arb #(.A_W(A_W), .B_W(B_W)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req0_i(req0_i), .a0_i(a0_i), .b0_i(b0_i),
    .req1_i(req1_i), .a1_i(a1_i), .b1_i(b1_i),
    .gnt_o(gnt_o), .busy_o(busy_o), .prod_o(prod_o),
    .done0_o(done0_o), .done1_o(done1_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic           r0;
    logic [A_W-1:0] a0;
    logic [B_W-1:0] b0;
    logic           r1;
    logic [A_W-1:0] a1;
    logic [B_W-1:0] b1;
    logic [1:0]     gnt;
    logic [P_W-1:0] prod;
    int             lat;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Counts edges until a done pulse is visible; gives up after budget edges.
  task automatic wait_done(input int budget, output int lat);
    lat = 0;
    while (!(done0_o || done1_o) && lat < budget) begin
      tick();
      lat++;
    end
  endtask

  initial begin
    int   lat;
    logic [P_W-1:0] prod_hold;

    vecs[0] = '{1'b1, 8'h1F, 4'h2, 1'b0, 8'h00, 4'h0, 2'b01, 12'h03E, B_W};
    vecs[1] = '{1'b0, 8'h00, 4'h0, 1'b1, 8'h1D, 4'h3, 2'b10, 12'h057, B_W};
    vecs[2] = '{1'b1, 8'hFF, 4'hF, 1'b0, 8'h00, 4'h0, 2'b01, 12'hEF1, B_W};
    vecs[3] = '{1'b1, 8'h00, 4'h9, 1'b0, 8'h00, 4'h0, 2'b01, 12'h000, ZLAT};
    vecs[4] = '{1'b0, 8'h00, 4'h0, 1'b1, 8'h55, 4'h0, 2'b10, 12'h000, ZLAT};
    vecs[5] = '{1'b0, 8'h00, 4'h0, 1'b1, 8'hFF, 4'hF, 2'b10, 12'hEF1, B_W};
    vecs[6] = '{1'b1, 8'h80, 4'h8, 1'b0, 8'h00, 4'h0, 2'b01, 12'h400, B_W};
    vecs[7] = '{1'b0, 8'h00, 4'h0, 1'b1, 8'h01, 4'h1, 2'b10, 12'h001, B_W};

    rst_ni = 1'b0;
    req0_i = 1'b0; req1_i = 1'b0;
    a0_i = 8'h00; b0_i = 4'h0; a1_i = 8'h00; b1_i = 4'h0;
    tick();
    tick();
    check("rst_gnt", gnt_o, 2'b00);
    check("rst_busy", busy_o, 1'b0);
    check("rst_prod", prod_o, 12'h000);
    check("rst_done", {done1_o, done0_o}, 2'b00);
    rst_ni = 1'b1;
    tick();
    check("idle_busy", busy_o, 1'b0);

    for (int i = 0; i < 8; i++) begin
      req0_i = vecs[i].r0; a0_i = vecs[i].a0; b0_i = vecs[i].b0;
      req1_i = vecs[i].r1; a1_i = vecs[i].a1; b1_i = vecs[i].b1;
      tick();
      check($sformatf("v%0d_gnt", i), gnt_o, vecs[i].gnt);
      check($sformatf("v%0d_busy", i), busy_o, 1'b1);
      a0_i = 8'($urandom); b0_i = 4'($urandom);
      a1_i = 8'($urandom); b1_i = 4'($urandom);
      wait_done(20, lat);
      check($sformatf("v%0d_lat", i), lat, vecs[i].lat);
      check($sformatf("v%0d_prod", i), prod_o, vecs[i].prod);
      check($sformatf("v%0d_done", i), {done1_o, done0_o}, vecs[i].gnt);
      check($sformatf("v%0d_gnt_done", i), gnt_o, vecs[i].gnt);
      req0_i = 1'b0; req1_i = 1'b0;
      tick();
      check($sformatf("v%0d_idle", i), {gnt_o, busy_o, done1_o, done0_o}, 5'b00000);
      check($sformatf("v%0d_hold", i), prod_o, vecs[i].prod);
    end

    // Simultaneous requests right after reset: requester 0 wins the tie.
    rst_ni = 1'b0;
    #2;
    rst_ni = 1'b1;
    req0_i = 1'b1; a0_i = 8'hFF; b0_i = 4'hF;
    req1_i = 1'b1; a1_i = 8'h1D; b1_i = 4'h3;
    tick();
    check("tie_gnt", gnt_o, 2'b01);
    wait_done(20, lat);
    check("tie_lat0", lat, B_W);
    check("tie_done0", {done1_o, done0_o}, 2'b01);
    check("tie_prod0", prod_o, 12'hEF1);
    req0_i = 1'b0;
    tick();
    wait_done(20, lat);
    check("tie_gap", lat + 1, B_W + 2);
    check("tie_done1", {done1_o, done0_o}, 2'b10);
    check("tie_prod1", prod_o, 12'h057);
    req1_i = 1'b0;
    tick();

    // Both requests held through four operations: service must alternate.
    req0_i = 1'b1; a0_i = 8'h03; b0_i = 4'h5;
    req1_i = 1'b1; a1_i = 8'h07; b1_i = 4'h6;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) tick();
      wait_done(20, lat);
      if (k > 0) check($sformatf("fair%0d_gap", k), lat + 1, B_W + 2);
      check($sformatf("fair%0d_owner", k), {done1_o, done0_o}, (k % 2 == 0) ? 2'b01 : 2'b10);
      check($sformatf("fair%0d_prod", k), prod_o, (k % 2 == 0) ? 12'h00F : 12'h02A);
    end
    req0_i = 1'b0; req1_i = 1'b0;
    tick();
    tick();

    // Reset during the second CALC cycle aborts silently; the held request then completes.
    req0_i = 1'b1; a0_i = 8'h1F; b0_i = 4'h2;
    tick();
    check("mid_gnt", gnt_o, 2'b01);
    tick();
    prod_hold = prod_o;
    check("mid_prev_prod", prod_hold, 12'h02A);
    rst_ni = 1'b0;
    #1;
    check("mid_rst_state", {gnt_o, busy_o, done1_o, done0_o}, 5'b00000);
    check("mid_rst_prod", prod_o, 12'h000);
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("mid_nodone%0d", k), {done1_o, done0_o}, 2'b00);
    end
    rst_ni = 1'b1;
    wait_done(20, lat);
    check("mid_lat", lat, B_W + 1);
    check("mid_done0", {done1_o, done0_o}, 2'b01);
    check("mid_prod", prod_o, 12'h03E);
    req0_i = 1'b0;
    tick();
    check("end_idle", {gnt_o, busy_o}, 3'b000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
